// File: rtl/scalar_scoreboard_if.sv
// scalar_scoreboard_if
// Bundles the dispatch, issue and writeback signals of the scalar scoreboard.
//   master : the pipeline side (dispatch, issue and writeback stages) that drives
//            requests and observes the scoreboard state.
//   slave  : the scoreboard itself.
// Signals:
//   disp_valid/disp_fu/disp_rd_en/disp_rd/disp_rs1/disp_rs2 : dispatch request
//   disp_ready  : dispatch accepted this cycle
//   issue_ready : per FU, row holds an instruction whose operands are all ready
//   issue_fire  : per FU, issue has read that row's operands
//   fu_rd/fu_rs1/fu_rs2 : per FU row register fields, FU k in bits [5k+4:5k]
//   fu_busy     : per FU row busy bits
//   wb_valid/wb_fu : FU completion
interface scalar_scoreboard_if #(
  parameter int NFU = 3
);
  logic           disp_valid;
  logic [1:0]     disp_fu;
  logic           disp_rd_en;
  logic [4:0]     disp_rd;
  logic [4:0]     disp_rs1;
  logic [4:0]     disp_rs2;
  logic           disp_ready;
  logic [NFU-1:0] issue_ready;
  logic [NFU-1:0] issue_fire;
  logic [NFU*5-1:0] fu_rd;
  logic [NFU*5-1:0] fu_rs1;
  logic [NFU*5-1:0] fu_rs2;
  logic [NFU-1:0] fu_busy;
  logic           wb_valid;
  logic [1:0]     wb_fu;

  modport master (
    output disp_valid, disp_fu, disp_rd_en, disp_rd, disp_rs1, disp_rs2,
    output issue_fire, wb_valid, wb_fu,
    input  disp_ready, issue_ready, fu_rd, fu_rs1, fu_rs2, fu_busy
  );

  modport slave (
    input  disp_valid, disp_fu, disp_rd_en, disp_rd, disp_rs1, disp_rs2,
    input  issue_fire, wb_valid, wb_fu,
    output disp_ready, issue_ready, fu_rd, fu_rs1, fu_rs2, fu_busy
  );
endinterface

// File: rtl/scalar_scoreboard.sv
// scalar_scoreboard
// Scoreboard for the scalar side of the tensor core, between dispatch and issue.
// Holds one function-unit status row per scalar FU (0=ALU, 1=LD_ST, 2=BRANCH)
// and a register result status table (busy + producer tag per register).
// Dispatch fills rows and resolves RAW producer tags, issue is told which rows
// have all operands ready, and writeback retires rows and producer tags.
// Ports:
//   CLK  : clock
//   nRST : synchronous active-low reset, clears every row and register entry
//   sb   : scalar_scoreboard_if slave modport (dispatch / issue / writeback)
// Producer tags: 0 = no pending producer, k+1 = FU k.
module scalar_scoreboard #(
  parameter int NREGS = 32,
  parameter int NFU   = 3,
  parameter int TAG_W = 2
) (
  input logic               CLK,
  input logic               nRST,
  scalar_scoreboard_if.slave sb
);

  // Register index width matches the 5-bit register fields of the interface.
  localparam int RW = 5;

  typedef struct packed {
    logic             busy;
    logic             issued;
    logic             rd_en;
    logic [RW-1:0]    rd;
    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
  } row_t;

  row_t             rows_q    [NFU];
  row_t             rows_d    [NFU];
  logic             rst_busy_q [NREGS];
  logic             rst_busy_d [NREGS];
  logic [TAG_W-1:0] rst_tag_q  [NREGS];
  logic [TAG_W-1:0] rst_tag_d  [NREGS];

  logic             wb_hit;
  logic [TAG_W-1:0] wb_tag;
  logic [RW-1:0]    wb_rd;
  logic             wb_rd_en;
  logic             fu_ok;
  logic             sel_busy;
  logic             waw;
  logic             disp_acc;
  logic [TAG_W-1:0] t1_new;
  logic [TAG_W-1:0] t2_new;
  logic [NFU-1:0]   issue_rdy;

  // Writeback only counts when it names an existing, busy row.
  always_comb begin
    wb_hit   = 1'b0;
    wb_tag   = '0;
    wb_rd    = '0;
    wb_rd_en = 1'b0;
    for (int k = 0; k < NFU; k++) begin
      if (sb.wb_valid && sb.wb_fu == 2'(k) && rows_q[k].busy) begin
        wb_hit   = 1'b1;
        wb_tag   = TAG_W'(k + 1);
        wb_rd    = rows_q[k].rd;
        wb_rd_en = rows_q[k].rd_en;
      end
    end
  end

  // Dispatch acceptance. Busy and WAW are judged on the registered state only,
  // so a row retiring this very cycle still blocks a new dispatch into it.
  always_comb begin
    fu_ok    = 1'b0;
    sel_busy = 1'b0;
    for (int k = 0; k < NFU; k++) begin
      if (sb.disp_fu == 2'(k)) begin
        fu_ok    = 1'b1;
        sel_busy = rows_q[k].busy;
      end
    end
    waw      = sb.disp_rd_en && (sb.disp_rd != '0) && rst_busy_q[sb.disp_rd];
    disp_acc = sb.disp_valid && fu_ok && !sel_busy && !waw;
  end

  assign sb.disp_ready = disp_acc;

  // Source producer tags, with a bypass for a producer retiring in the same cycle.
  always_comb begin
    t1_new = '0;
    t2_new = '0;
    if (sb.disp_rs1 != '0 && rst_busy_q[sb.disp_rs1]) t1_new = rst_tag_q[sb.disp_rs1];
    if (sb.disp_rs2 != '0 && rst_busy_q[sb.disp_rs2]) t2_new = rst_tag_q[sb.disp_rs2];
    if (wb_hit && t1_new == wb_tag) t1_new = '0;
    if (wb_hit && t2_new == wb_tag) t2_new = '0;
  end

  always_comb begin
    for (int k = 0; k < NFU; k++) begin
      issue_rdy[k] = rows_q[k].busy && !rows_q[k].issued &&
                     (rows_q[k].t1 == '0) && (rows_q[k].t2 == '0);
    end
  end

  // Next-state for rows and register status. The dispatch set to the register
  // table is applied after the writeback clear so that it wins on a collision.
  always_comb begin
    for (int k = 0; k < NFU; k++) rows_d[k] = rows_q[k];
    for (int r = 0; r < NREGS; r++) begin
      rst_busy_d[r] = rst_busy_q[r];
      rst_tag_d[r]  = rst_tag_q[r];
    end

    for (int k = 0; k < NFU; k++) begin
      if (wb_hit && sb.wb_fu == 2'(k)) begin
        rows_d[k].busy   = 1'b0;
        rows_d[k].issued = 1'b0;
      end else begin
        if (sb.issue_fire[k] && issue_rdy[k]) rows_d[k].issued = 1'b1;
        if (wb_hit && rows_q[k].t1 == wb_tag) rows_d[k].t1 = '0;
        if (wb_hit && rows_q[k].t2 == wb_tag) rows_d[k].t2 = '0;
        if (disp_acc && sb.disp_fu == 2'(k)) begin
          rows_d[k].busy   = 1'b1;
          rows_d[k].issued = 1'b0;
          rows_d[k].rd_en  = sb.disp_rd_en;
          rows_d[k].rd     = sb.disp_rd;
          rows_d[k].rs1    = sb.disp_rs1;
          rows_d[k].rs2    = sb.disp_rs2;
          rows_d[k].t1     = t1_new;
          rows_d[k].t2     = t2_new;
        end
      end
    end

    // A later producer may own the register already; only the owner clears it.
    if (wb_hit && wb_rd_en && wb_rd != '0 && rst_tag_q[wb_rd] == wb_tag) begin
      rst_busy_d[wb_rd] = 1'b0;
      rst_tag_d[wb_rd]  = '0;
    end

    if (disp_acc && sb.disp_rd_en && sb.disp_rd != '0) begin
      rst_busy_d[sb.disp_rd] = 1'b1;
      rst_tag_d[sb.disp_rd]  = TAG_W'(sb.disp_fu) + TAG_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 0; k < NFU; k++) rows_q[k] <= '0;
      for (int r = 0; r < NREGS; r++) begin
        rst_busy_q[r] <= 1'b0;
        rst_tag_q[r]  <= '0;
      end
    end else begin
      for (int k = 0; k < NFU; k++) rows_q[k] <= rows_d[k];
      for (int r = 0; r < NREGS; r++) begin
        rst_busy_q[r] <= rst_busy_d[r];
        rst_tag_q[r]  <= rst_tag_d[r];
      end
    end
  end

  always_comb begin
    sb.issue_ready = issue_rdy;
    sb.fu_busy     = '0;
    sb.fu_rd       = '0;
    sb.fu_rs1      = '0;
    sb.fu_rs2      = '0;
    for (int k = 0; k < NFU; k++) begin
      sb.fu_busy[k]       = rows_q[k].busy;
      sb.fu_rd[5*k +: 5]  = rows_q[k].rd;
      sb.fu_rs1[5*k +: 5] = rows_q[k].rs1;
      sb.fu_rs2[5*k +: 5] = rows_q[k].rs2;
    end
  end

endmodule
